// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier with signed/unsigned modes, overflow flag and
// valid/ready handshakes. One multiply in flight; one partial-product add per cycle.
module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 c_out
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    ma;
  logic [WIDTH-1:0] mb;
  logic [PW-1:0]    acc;
  logic             neg;
  logic             sgn;
  logic [PW-1:0]    result;

  // Magnitude of an operand; in signed mode the most negative value maps to
  // 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    mag = (s && v[WIDTH-1]) ? -v : v;
  endfunction

  // Overflow: the full product does not fit back into a WIDTH-bit operand.
  function automatic logic overflow(input logic [PW-1:0] r, input logic s);
    logic [WIDTH:0] top;
    top = r[PW-1:WIDTH-1];
    if (s)
      overflow = !((&top) || !(|top));
    else
      overflow = |r[PW-1:WIDTH];
  endfunction

  assign result = neg ? -acc : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      p         <= '0;
      c_out     <= 1'b0;
      cnt       <= '0;
      ma        <= '0;
      mb        <= '0;
      acc       <= '0;
      neg       <= 1'b0;
      sgn       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ma       <= {{WIDTH{1'b0}}, mag(a, signed_mode)};
            mb       <= mag(b, signed_mode);
            neg      <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            sgn      <= signed_mode;
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          // Counts 0..WIDTH-1 are the add iterations; the final count applies
          // the sign fix and publishes the result.
          if (cnt == LAST_CNT) begin
            p         <= result;
            c_out     <= overflow(result, sgn);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            if (mb[0])
              acc <= acc + ma;
            ma  <= ma << 1;
            mb  <= mb >> 1;
            cnt <= cnt + CNT_ONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: directed table, exhaustive WIDTH=4, random WIDTH=8,
// backpressure and mid-calculation reset sequences.
module tb_seq_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        iv4, ir4, s4, ov4, or4, c4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;
  logic        iv8, ir8, s8, ov8, or8, c8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  int errors = 0;
  int checks = 0;

  seq_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .signed_mode(s4), .out_valid(ov4), .out_ready(or4), .p(p4), .c_out(c4)
  );

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .signed_mode(s8), .out_valid(ov8), .out_ready(or8), .p(p8), .c_out(c8)
  );

  typedef struct {
    int          w;
    int          a;
    int          b;
    bit          s;
    logic [15:0] p;
    logic        c;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: interpret operands as integers, multiply, then range-check.
  function automatic void model(input int w, input int av, input int bv, input bit s,
                                output logic [15:0] pe, output logic ce);
    longint x, y, prod, lo, hi;
    x = av;
    y = bv;
    if (s && x >= (longint'(1) << (w - 1))) x = x - (longint'(1) << w);
    if (s && y >= (longint'(1) << (w - 1))) y = y - (longint'(1) << w);
    prod = x * y;
    lo = s ? -(longint'(1) << (w - 1)) : 0;
    hi = s ? (longint'(1) << (w - 1)) - 1 : (longint'(1) << w) - 1;
    ce = (prod < lo) || (prod > hi);
    pe = 16'(prod & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic run(input int w, input int av, input int bv, input bit s,
                     output logic [15:0] pr, output logic cr, output int lat);
    int guard;
    @(negedge clk);
    if (w == 4) begin
      iv4 = 1'b1; a4 = av[3:0]; b4 = bv[3:0]; s4 = s;
    end else begin
      iv8 = 1'b1; a8 = av[7:0]; b8 = bv[7:0]; s8 = s;
    end
    guard = 0;
    while (((w == 4) ? ir4 : ir8) !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("in_ready_timeout", 64'(guard), 64'(0));
    @(posedge clk);
    #1;
    iv4 = 1'b0;
    iv8 = 1'b0;
    lat = 0;
    while (((w == 4) ? ov4 : ov8) !== 1'b1 && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    pr = (w == 4) ? {8'h00, p4} : p8;
    cr = (w == 4) ? c4 : c8;
  endtask

  initial begin
    logic [15:0] pr, pe;
    logic        cr, ce;
    int          lat;

    tbl[0]  = '{4, 15, 15, 1'b0, 16'h00E1, 1'b1};
    tbl[1]  = '{4, 3,  5,  1'b0, 16'h000F, 1'b0};
    tbl[2]  = '{4, 8,  8,  1'b1, 16'h0040, 1'b1};
    tbl[3]  = '{4, 13, 5,  1'b1, 16'h00F1, 1'b1};
    tbl[4]  = '{4, 14, 3,  1'b1, 16'h00FA, 1'b0};
    tbl[5]  = '{4, 0,  15, 1'b1, 16'h0000, 1'b0};
    tbl[6]  = '{4, 7,  7,  1'b0, 16'h0031, 1'b1};
    tbl[7]  = '{4, 15, 15, 1'b1, 16'h0001, 1'b0};
    tbl[8]  = '{4, 8,  7,  1'b1, 16'h00C8, 1'b1};
    tbl[9]  = '{8, 255, 255, 1'b0, 16'hFE01, 1'b1};
    tbl[10] = '{8, 128, 128, 1'b1, 16'h4000, 1'b1};
    tbl[11] = '{8, 12,  10,  1'b0, 16'h0078, 1'b0};

    rst_n = 1'b0;
    iv4 = 1'b0; a4 = '0; b4 = '0; s4 = 1'b0; or4 = 1'b1;
    iv8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0; or8 = 1'b1;
    #12;
    check("reset_in_ready4", 64'(ir4), 64'(1));
    check("reset_out_valid4", 64'(ov4), 64'(0));
    check("reset_p4", 64'(p4), 64'(0));
    check("reset_c_out4", 64'(c4), 64'(0));
    check("reset_in_ready8", 64'(ir8), 64'(1));
    check("reset_p8", 64'(p8), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run(tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].s, pr, cr, lat);
      check($sformatf("table%0d_p", i), 64'(pr), 64'(tbl[i].p));
      check($sformatf("table%0d_c", i), 64'(cr), 64'(tbl[i].c));
      check($sformatf("table%0d_latency", i), 64'(lat), 64'(tbl[i].w + 1));
    end

    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++) begin
          run(4, x, y, s[0], pr, cr, lat);
          model(4, x, y, s[0], pe, ce);
          check($sformatf("exh_p a=%0d b=%0d s=%0d", x, y, s), 64'(pr), 64'(pe));
          check($sformatf("exh_c a=%0d b=%0d s=%0d", x, y, s), 64'(cr), 64'(ce));
          check($sformatf("exh_latency a=%0d b=%0d", x, y), 64'(lat), 64'(5));
        end

    for (int i = 0; i < 60; i++) begin
      int x, y;
      bit s;
      x = int'($urandom_range(255, 0));
      y = int'($urandom_range(255, 0));
      s = 1'($urandom_range(1, 0));
      run(8, x, y, s, pr, cr, lat);
      model(8, x, y, s, pe, ce);
      check($sformatf("rnd8_p a=%0d b=%0d s=%0d", x, y, s), 64'(pr), 64'(pe));
      check($sformatf("rnd8_c a=%0d b=%0d s=%0d", x, y, s), 64'(cr), 64'(ce));
      check("rnd8_latency", 64'(lat), 64'(9));
    end

    // Backpressure: result must hold in DONE while the consumer stalls.
    or4 = 1'b0;
    run(4, 3, 5, 1'b0, pr, cr, lat);
    check("bp_first_p", 64'(pr), 64'(8'h0F));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_out_valid_%0d", i), 64'(ov4), 64'(1));
      check($sformatf("bp_p_%0d", i), 64'(p4), 64'(8'h0F));
      check($sformatf("bp_c_%0d", i), 64'(c4), 64'(0));
      check($sformatf("bp_in_ready_%0d", i), 64'(ir4), 64'(0));
    end
    @(negedge clk);
    or4 = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_out_valid", 64'(ov4), 64'(0));
    check("bp_release_in_ready", 64'(ir4), 64'(1));
    check("bp_p_kept_in_idle", 64'(p4), 64'(8'h0F));

    // Asynchronous reset two cycles into a 7*7.
    @(negedge clk);
    iv4 = 1'b1; a4 = 4'd7; b4 = 4'd7; s4 = 1'b0;
    @(posedge clk);
    #1;
    iv4 = 1'b0;
    check("rst_test_accepted", 64'(ir4), 64'(0));
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 64'(ov4), 64'(0));
    check("rst_mid_p", 64'(p4), 64'(0));
    check("rst_mid_in_ready", 64'(ir4), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    run(4, 2, 3, 1'b0, pr, cr, lat);
    check("rst_after_p", 64'(pr), 64'(8'h06));
    check("rst_after_c", 64'(cr), 64'(0));
    check("rst_after_latency", 64'(lat), 64'(5));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
